// File: rtl/seq_pkg.sv
// Shared state and constant definitions for the sequence-detector path
// (serializer front end and detector).
package seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_PAR   = 2'b10
    } ser_state_t;

    localparam logic SER_IDLE_DEFAULT = 1'b0;

endpackage

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end feeding the sequence detector's x input.
// Optional even-parity bit after each word when SEQ_SER_PARITY_EN is defined.
module seq_bit_serializer
    import seq_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter logic        IDLE_LEVEL = SER_IDLE_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int unsigned     CntW    = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    ser_state_t       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    // Holds the bits still to be sent; the bit on ser_out has already left it.
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             word_done_q, word_done_d;
    logic             last_bit;
    logic             accept;
`ifdef SEQ_SER_PARITY_EN
    logic             par_q, par_d;
`endif

    function automatic logic head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] drop_head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    assign last_bit = (state_q == S_SHIFT) && (cnt_q == LastCnt);

`ifdef SEQ_SER_PARITY_EN
    assign in_ready = (state_q == S_IDLE) || (state_q == S_PAR);
`else
    assign in_ready = (state_q == S_IDLE) || last_bit;
`endif

    assign accept = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        ser_out_d   = IDLE_LEVEL;
        ser_valid_d = 1'b0;
        word_done_d = 1'b0;
`ifdef SEQ_SER_PARITY_EN
        par_d       = par_q;
`endif
        if (accept) begin
            state_d     = S_SHIFT;
            cnt_d       = '0;
            shift_d     = drop_head(in_data);
            ser_out_d   = head(in_data);
            ser_valid_d = 1'b1;
`ifdef SEQ_SER_PARITY_EN
            par_d       = ^in_data;
`endif
        end else if (state_q == S_SHIFT) begin
            if (!last_bit) begin
                cnt_d       = cnt_q + 1'b1;
                shift_d     = drop_head(shift_q);
                ser_out_d   = head(shift_q);
                ser_valid_d = 1'b1;
`ifdef SEQ_SER_PARITY_EN
                word_done_d = 1'b0;
`else
                word_done_d = (cnt_d == LastCnt);
`endif
            end else begin
`ifdef SEQ_SER_PARITY_EN
                state_d     = S_PAR;
                ser_out_d   = par_q;
                ser_valid_d = 1'b1;
                word_done_d = 1'b1;
`else
                state_d     = S_IDLE;
                cnt_d       = '0;
`endif
            end
        end else if (state_q == S_PAR) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            ser_out_q   <= IDLE_LEVEL;
            ser_valid_q <= 1'b0;
            word_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            word_done_q <= word_done_d;
        end
    end

`ifdef SEQ_SER_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

    assign ser_out   = ser_out_q;
    assign ser_valid = ser_valid_q;
    assign word_done = word_done_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Scoreboard bench: DUT a is MSB-first/idle-0, DUT b is LSB-first/idle-1.
module tb_seq_bit_serializer;

`ifdef SEQ_SER_PARITY_EN
    localparam bit Par = 1'b1;
`else
    localparam bit Par = 1'b0;
`endif
    localparam int WordLen = 8 + int'(Par);

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] a_data, b_data;
    logic       a_valid, b_valid;
    logic       a_ready, a_ser, a_sv, a_done, a_busy;
    logic       b_ready, b_ser, b_sv, b_done, b_busy;

    seq_bit_serializer #(
        .WIDTH     (8),
        .MSB_FIRST (1'b1),
        .IDLE_LEVEL(1'b0)
    ) u_dut_a (
        .clk      (clk),
        .reset    (reset),
        .in_data  (a_data),
        .in_valid (a_valid),
        .in_ready (a_ready),
        .ser_out  (a_ser),
        .ser_valid(a_sv),
        .word_done(a_done),
        .busy     (a_busy)
    );

    seq_bit_serializer #(
        .WIDTH     (8),
        .MSB_FIRST (1'b0),
        .IDLE_LEVEL(1'b1)
    ) u_dut_b (
        .clk      (clk),
        .reset    (reset),
        .in_data  (b_data),
        .in_valid (b_valid),
        .in_ready (b_ready),
        .ser_out  (b_ser),
        .ser_valid(b_sv),
        .word_done(b_done),
        .busy     (b_busy)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    logic [1:0] qa[$];  // {bit, word_done}
    logic [1:0] qb[$];
    int         rem_a = 0, rem_b = 0;
    int         run_a = 0, max_run_a = 0;
    logic       last_acc_a = 1'b0, last_acc_b = 1'b0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_vec++;
        assert (obs === exp_v)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic push_word(input bit lsb_first, input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
            logic bv, dv;
            bv = lsb_first ? w[i] : w[7-i];
            dv = (i == 7) && !Par;
            if (lsb_first) qb.push_back({bv, dv});
            else qa.push_back({bv, dv});
        end
        if (Par) begin
            if (lsb_first) qb.push_back({^w, 1'b1});
            else qa.push_back({^w, 1'b1});
        end
    endtask

    task automatic check_stream(input string pfx, input int rem, input logic idle,
                                input logic [1:0] e, input logic sv, input logic so,
                                input logic dn, input logic bz);
        if (rem > 0) begin
            chk({pfx, " ser_valid"}, sv, 1);
            chk({pfx, " ser_out"}, so, e[1]);
            chk({pfx, " word_done"}, dn, e[0]);
            chk({pfx, " busy"}, bz, 1);
        end else begin
            chk({pfx, " idle ser_valid"}, sv, 0);
            chk({pfx, " idle ser_out"}, so, idle);
            chk({pfx, " idle word_done"}, dn, 0);
            chk({pfx, " idle busy"}, bz, 0);
        end
    endtask

    task automatic tick();
        logic       acc_a, acc_b;
        logic [7:0] wa, wb;
        logic [1:0] ea, eb;
        chk("a in_ready", a_ready, rem_a <= 1);
        chk("b in_ready", b_ready, rem_b <= 1);
        acc_a = a_valid && (rem_a <= 1);
        acc_b = b_valid && (rem_b <= 1);
        wa = a_data;
        wb = b_data;
        @(posedge clk);
        #1;
        if (acc_a) begin
            push_word(1'b0, wa);
            rem_a = WordLen;
        end else if (rem_a > 0) rem_a--;
        if (acc_b) begin
            push_word(1'b1, wb);
            rem_b = WordLen;
        end else if (rem_b > 0) rem_b--;
        ea = 2'bxx;
        eb = 2'bxx;
        if (rem_a > 0 && qa.size() > 0) ea = qa.pop_front();
        if (rem_b > 0 && qb.size() > 0) eb = qb.pop_front();
        check_stream("a", rem_a, 1'b0, ea, a_sv, a_ser, a_done, a_busy);
        check_stream("b", rem_b, 1'b1, eb, b_sv, b_ser, b_done, b_busy);
        run_a = a_sv ? run_a + 1 : 0;
        if (run_a > max_run_a) max_run_a = run_a;
        last_acc_a = acc_a;
        last_acc_b = acc_b;
    endtask

    task automatic idle(input int n);
        a_valid = 1'b0;
        b_valid = 1'b0;
        repeat (n) begin
            a_data = 8'($urandom);
            b_data = 8'($urandom);
            tick();
        end
    endtask

    task automatic send_a(input logic [7:0] w);
        a_valid = 1'b1;
        a_data  = w;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (last_acc_a) break;
        end
        chk("a accept", last_acc_a, 1);
    endtask

    task automatic send_b(input logic [7:0] w);
        b_valid = 1'b1;
        b_data  = w;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (last_acc_b) break;
        end
        chk("b accept", last_acc_b, 1);
    endtask

    initial begin
        reset   = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_data  = 8'h00;
        b_data  = 8'h00;
        #2;
        chk("rst a ser_valid", a_sv, 0);
        chk("rst a ser_out", a_ser, 0);
        chk("rst a word_done", a_done, 0);
        chk("rst a busy", a_busy, 0);
        chk("rst b ser_out", b_ser, 1);
        chk("rst b ser_valid", b_sv, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Single word, MSB first.
        send_a(8'hF0);
        idle(10);

        // Back-to-back words with in_valid held: no bubble between them.
        max_run_a = 0;
        send_a(8'hA5);
        send_a(8'h3C);
        idle(10);
        chk("a b2b contiguous", 8'(max_run_a), 8'(2 * WordLen));

        // LSB first with idle level 1.
        send_b(8'h01);
        idle(10);

        // Reset three bits into a word.
        send_a(8'hFF);
        a_valid = 1'b0;
        tick();
        tick();
        #2 reset = 1'b1;
        #1;
        chk("mid-rst a ser_valid", a_sv, 0);
        chk("mid-rst a ser_out", a_ser, 0);
        chk("mid-rst a word_done", a_done, 0);
        chk("mid-rst a busy", a_busy, 0);
        chk("mid-rst a in_ready", a_ready, 1);
        qa.delete();
        rem_a = 0;
        run_a = 0;
        @(posedge clk);
        #1 reset = 1'b0;
        idle(10);

        // in_valid pulse while busy must be ignored.
        send_a(8'h81);
        a_valid = 1'b0;
        tick();
        tick();
        a_valid = 1'b1;
        a_data  = 8'h55;
        tick();
        a_valid = 1'b0;
        idle(10);

        // Parity case when enabled; plain word otherwise.
        send_a(8'h07);
        idle(11);

        chk("a queue drained", 8'(qa.size()), 0);
        chk("b queue drained", 8'(qb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seq_bit_serializer.md
Name: seq_bit_serializer

Overview:
- Parallel-to-serial front end for the FSM sequence-detector path.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clk on ser_out. ser_out drives the downstream detector's x input.
- Holds ser_out at IDLE_LEVEL between words, so idle gaps cannot fabricate a detection.

Parameters:
- WIDTH, 8: bits per input word; legal range 2..32.
- MSB_FIRST, 1: 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- IDLE_LEVEL, 0: value driven on ser_out while no word is shifting.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  parallel word; sampled only on the accept edge.
- in_valid  input  1  in_data holds a word.
- in_ready  output  1  block accepts a word this cycle.
- ser_out  output  1  serial bit; connects to detector x.
- ser_valid  output  1  ser_out carries a data (or parity) bit this cycle.
- word_done  output  1  one-cycle pulse during the final bit of a word.
- busy  output  1  a word is in flight (state != S_IDLE).

Behaviour:
- Reset (asynchronous, immediate) forces:
  - state = S_IDLE, shift register = 0, bit counter = 0.
  - ser_out = IDLE_LEVEL, ser_valid = 0, word_done = 0, busy = 0.
  - in_ready = 1 in the first cycle after reset deasserts.
- Accept: in_valid && in_ready on a rising edge captures in_data into the shift register. in_data may change freely after that edge.
- Latency: first bit appears on ser_out, with ser_valid = 1, in the cycle after the accept edge. The word occupies exactly WIDTH consecutive cycles (WIDTH+1 with parity).
- States:
  - S_IDLE: ser_out = IDLE_LEVEL, ser_valid = 0, in_ready = 1. Accept -> S_SHIFT, counter = 0.
  - S_SHIFT: ser_out = current head bit, ser_valid = 1. Counter increments each cycle. At counter == WIDTH-1 the cycle is the last bit:
    - accept in that cycle -> stay in S_SHIFT, counter = 0 (back-to-back).
    - no accept -> S_IDLE.
- in_ready = (state == S_IDLE) || (last data bit of S_SHIFT with parity disabled). Zero-bubble streaming is required.
- in_valid while in_ready = 0 is ignored; the source holds the word until accepted.
- word_done = 1 exactly in the last bit cycle of each word.
- Outputs ser_out, ser_valid and word_done are registered (glitch-free into the detector).
- Counter width = $clog2(WIDTH+1). No wrap beyond WIDTH; S_IDLE/S_SHIFT encode in 2 bits.
- Reset mid-word: the in-flight word is discarded and is not resumed after reset.

Optional Feature:
- Macro SEQ_SER_PARITY_EN.
- Defined:
  - After the last data bit the FSM enters S_PAR for one cycle: ser_out = even parity (XOR of the captured word), ser_valid = 1, word_done = 1.
  - word_done does not fire on the last data bit.
  - in_ready is low during the last data bit and high during S_PAR, which permits back-to-back words.
- Undefined: S_PAR and the parity logic are absent; behaviour is as above.

Decomposition:
- Package seq_pkg:
  - typedef ser_state_t (S_IDLE = 2'b00, S_SHIFT = 2'b01, S_PAR = 2'b10).
  - Constant SER_IDLE_DEFAULT = 1'b0.
  - Shared with the detector's state definitions.
- No sub-module. The counter and shift register are inline; a separate module would add ports without adding reuse.

Test Plan:
- WIDTH=8, MSB_FIRST=1, accept 0xF0 -> ser_out 1,1,1,1,0,0,0,0 on cycles 1..8 after accept, ser_valid high for those 8 cycles, word_done in cycle 8 only. Downstream detector asserts y once.
- Back-to-back 0xA5 then 0x3C with in_valid held -> 16 contiguous ser_valid cycles, no bubble, in_ready high in cycles 0 and 8.
- MSB_FIRST=0, accept 0x01 -> first ser_out = 1, next 7 = 0. IDLE_LEVEL=1 -> ser_out = 1 before and after the word with ser_valid = 0.
- Assert reset after 3 bits of 0xFF -> ser_valid drops and ser_out = IDLE_LEVEL in the same cycle. After release: in_ready = 1, busy = 0, no residual bits.
- in_valid pulsed while busy (in_ready = 0) with 0x55 -> word not captured, stream unchanged.
- SEQ_SER_PARITY_EN defined, accept 0x07 -> 8 data bits then parity 1 in cycle 9, word_done in cycle 9 only, in_ready low in cycle 8.
